// File: rtl/cic3_sdm_pkg.sv
// Shared types and width helpers for the CIC3 interpolator + 2nd-order sigma-delta DAC.
// Optional feature macro used by this slice: CIC3_SDM_DITHER_EN.
package cic3_sdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_IN_W   = 16;
  localparam int unsigned DEF_R_LOG2 = 6;

  // CIC register width: input + growth of R^2 plus one guard bit
  function automatic int unsigned cic_w(input int unsigned in_w, input int unsigned r_log2);
    return in_w + 2 * r_log2 + 1;
  endfunction

  function automatic int unsigned mod_w(input int unsigned in_w);
    return in_w + 4;
  endfunction

endpackage

// File: rtl/sdm2_core.sv
// Second-order CIFB sigma-delta modulator with saturating integrators and registered 1-bit output.
// Define CIC3_SDM_DITHER_EN to add +/-1 LSB LFSR dither ahead of the quantizer.
module sdm2_core
  import cic3_sdm_pkg::*;
#(
  parameter int unsigned IN_W = DEF_IN_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic signed [IN_W-1:0] x,
  output logic                   dout
);

  localparam int unsigned MW = mod_w(IN_W);
  localparam int unsigned SW = MW + 2;
  localparam logic signed [SW-1:0] HALF   = SW'(2 ** (IN_W - 1));
  localparam logic signed [SW-1:0] SAT_HI = SW'(2 ** (MW - 1) - 1);
  localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

  logic signed [MW-1:0] i1, i2, i1_next, i2_next;
  logic signed [SW-1:0] fb, q;

  function automatic logic signed [MW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[MW-1:0];
    else if (v < SAT_LO) return SAT_LO[MW-1:0];
    else                 return v[MW-1:0];
  endfunction

`ifdef CIC3_SDM_DITHER_EN
  localparam logic signed [SW-1:0] ONE = SW'(1);
  logic [15:0] lfsr;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`endif

  always_comb begin
    fb      = dout ? HALF : -HALF;
    i1_next = sat(SW'(i1) + SW'(x) - fb);
    i2_next = sat(SW'(i2) + SW'(i1) - fb);
`ifdef CIC3_SDM_DITHER_EN
    q       = SW'(i2_next) + (lfsr[0] ? ONE : -ONE);
`else
    q       = SW'(i2_next);
`endif
  end

  // Outside RUN the loop is parked at zero and the output idles at midscale
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i1   <= '0;
      i2   <= '0;
      dout <= 1'b0;
    end else if (!run) begin
      i1   <= '0;
      i2   <= '0;
      dout <= ~dout;
    end else begin
      i1   <= i1_next;
      i2   <= i2_next;
      dout <= ~q[SW-1];
    end
  end

endmodule

// File: rtl/cic3_sdm_dac.sv
// 1-bit DAC: 3-stage CIC interpolator (ratio 2^R_LOG2) feeding a 2nd-order sigma-delta modulator.
// Macro CIC3_SDM_DITHER_EN enables quantizer dither inside sdm2_core.
module cic3_sdm_dac
  import cic3_sdm_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned R_LOG2 = DEF_R_LOG2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            dout,
  output logic            underrun,
  input  logic            clear_underrun
);

  localparam int unsigned CW = cic_w(IN_W, R_LOG2);
  localparam logic [R_LOG2-1:0] PH_LAST = '1;

  state_t            state, state_next;
  logic [R_LOG2-1:0] phase;
  logic              running, accept, load, starve;

  logic signed [IN_W-1:0] last_sample, sample, x;
  logic signed [CW-1:0]   d1, d2, d3, y1, y2, y3, comb_q, int_in;
  logic signed [CW-1:0]   a1, a2, a3, a3_sh;
  logic                   stuff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == IDLE && in_valid) state_next = RUN;
  end

  always_comb begin
    running  = (state == RUN);
    in_ready = (state == IDLE) || (phase == PH_LAST);
    accept   = in_ready && in_valid;
    // A due slot always clocks the comb, with the held sample when starved
    load     = accept || (running && phase == PH_LAST);
    starve   = running && (phase == PH_LAST) && !in_valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     phase <= '0;
    else if (running) phase <= phase + 1'b1;
    else              phase <= '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            underrun <= 1'b0;
    else if (starve)         underrun <= 1'b1;
    else if (clear_underrun) underrun <= 1'b0;
  end

  always_comb begin
    sample = accept ? $signed(in_data) : last_sample;
    y1     = CW'(sample) - d1;
    y2     = y1 - d2;
    y3     = y2 - d3;
    int_in = stuff ? comb_q : '0;
    a3_sh  = a3 >>> (2 * R_LOG2);
    x      = a3_sh[IN_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_sample <= '0;
      d1          <= '0;
      d2          <= '0;
      d3          <= '0;
      comb_q      <= '0;
      stuff       <= 1'b0;
    end else begin
      stuff <= load;
      if (load) begin
        last_sample <= sample;
        d1          <= CW'(sample);
        d2          <= y1;
        d3          <= y2;
        comb_q      <= y3;
      end
    end
  end

  // Integrators wrap freely; the true output always fits CW bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a1 <= '0;
      a2 <= '0;
      a3 <= '0;
    end else if (!running) begin
      a1 <= '0;
      a2 <= '0;
      a3 <= '0;
    end else begin
      a1 <= a1 + int_in;
      a2 <= a2 + a1;
      a3 <= a3 + a2;
    end
  end

  sdm2_core #(
    .IN_W (IN_W)
  ) u_sdm (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (running),
    .x       (x),
    .dout    (dout)
  );

endmodule

// File: tb/tb_cic3_sdm_dac.sv
// Directed self-checking bench for cic3_sdm_dac: idle midscale, pacing, densities, underrun, reset.
module tb_cic3_sdm_dac;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        dout;
  logic        underrun;
  logic        clear_underrun;

  int n_tests = 0;
  int n_fail  = 0;
  bit running;
  int ph;
  logic exp_tog;
  int ones;

  always #5 clk = ~clk;

  cic3_sdm_dac #(
    .IN_W   (16),
    .R_LOG2 (6)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dout           (dout),
    .underrun       (underrun),
    .clear_underrun (clear_underrun)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_tests++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One clock: inputs are driven at negedge, outputs sampled at the next negedge
  task automatic step();
    bit hs;
    hs = in_valid && (!running || ph == 63);
    @(posedge clk);
    if (!running) begin
      exp_tog = ~exp_tog;
      if (hs) begin
        running = 1'b1;
        ph      = 0;
      end
    end else begin
      ph = (ph + 1) % 64;
    end
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n, input int win, output int n_ones);
    n_ones = 0;
    for (int i = 0; i < n; i++) begin
      step();
      check("in_ready_pace", in_ready, (!running || ph == 63));
      if (i >= n - win) n_ones += int'(dout);
    end
  endtask

  task automatic goto_last_phase();
    for (int i = 0; i < 64 && ph != 63; i++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; clear_underrun = 1'b0;
    running = 1'b0; ph = 0; exp_tog = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_dout", dout, 1'b0);
    check("reset_underrun", underrun, 1'b0);
    reset_n = 1'b1;

    // Idle: midscale toggling, always ready
    for (int i = 0; i < 100; i++) begin
      step();
      check("idle_dout", dout, exp_tog);
      check("idle_in_ready", in_ready, 1'b1);
      check("idle_underrun", underrun, 1'b0);
    end

    // Zero input: exactly half ones once settled
    in_valid = 1'b1;
    in_data  = 16'h0000;
    run_cycles(8192, 4096, ones);
    check_range("zero_density", ones, 2040, 2056);
    check("zero_underrun", underrun, 1'b0);

    // +0.5 FS: 75% ones
    in_data = 16'h4000;
    run_cycles(6144, 4096, ones);
    check_range("half_fs_density", ones, 3052, 3092);

    // Skip one sample, then clear, then set-wins
    goto_last_phase();
    check("pre_skip_underrun", underrun, 1'b0);
    in_valid = 1'b0;
    step();
    check("underrun_set", underrun, 1'b1);
    check("skip_not_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("underrun_sticky", underrun, 1'b1);
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    check("underrun_clear", underrun, 1'b0);
    goto_last_phase();
    check("still_paced", in_ready, 1'b1);
    in_valid = 1'b0;
    clear_underrun = 1'b1;
    step();
    check("underrun_set_wins", underrun, 1'b1);
    in_valid = 1'b1;
    clear_underrun = 1'b0;
    run_cycles(128, 1, ones);

    // Near full scale: saturation, ones density above 0.99
    in_data = 16'h7FFF;
    run_cycles(10000, 4096, ones);
    check_range("full_scale_density", ones, 4056, 4096);

    // Reset mid-RUN, at an arbitrary phase with dout high and underrun set
    for (int i = 0; i < 37; i++) step();
    for (int i = 0; i < 64 && dout !== 1'b1; i++) step();
    check("pre_reset_dout", dout, 1'b1);
    check("pre_reset_underrun", underrun, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrun_rst_in_ready", in_ready, 1'b1);
    check("midrun_rst_dout", dout, 1'b0);
    check("midrun_rst_underrun", underrun, 1'b0);
    running = 1'b0; ph = 0; exp_tog = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'h0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_idle_dout", dout, exp_tog);
      check("post_rst_idle_ready", in_ready, 1'b1);
    end

    // Restart: phase from 0, no residue from before the reset
    in_valid = 1'b1;
    run_cycles(2048, 1024, ones);
    check_range("post_rst_zero_density", ones, 508, 516);
    check("post_rst_underrun", underrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cic3_sdm_dac.md
CIC3_SDM_DAC -- requirements
Module: cic3_sdm_dac

Interface
REQ-001 SHALL have parameter IN_W, default 16, input PCM sample width (two's complement).
REQ-002 SHALL have parameter R_LOG2, default 6, log2 of the interpolation ratio R (R=64).
REQ-003 SHALL have port clk, input, 1, single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_data, input, IN_W, PCM sample at output rate/R.
REQ-006 SHALL have port in_valid, input, 1, in_data is valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-008 SHALL have port dout, output, 1, 1-bit sigma-delta stream at clk rate.
REQ-009 SHALL have port underrun, output, 1, sticky flag: a sample was due but not supplied.
REQ-010 SHALL have port clear_underrun, input, 1, synchronous clear of underrun.

Function
REQ-011 SHALL implement FSM with states IDLE and RUN; the state is IDLE after reset.
REQ-012 In IDLE: in_ready=1 and dout toggles 0,1,0,1 every clk (midscale); the CIC and modulator SHALL hold zero.
REQ-013 IDLE->RUN on the first in_valid&&in_ready handshake; phase counter SHALL load 0.
REQ-014 In RUN: the R_LOG2-bit phase counter SHALL increment each clk and wrap R-1->0; in_ready=1 only when phase==R-1.
REQ-015 The handshake at phase==R-1 SHALL feed the sample to the 3-stage comb (differential delay 1) at input rate.
REQ-016 If in_valid=0 at phase==R-1, the block SHALL reuse the previous sample, set underrun=1, and remain in RUN.
REQ-017 Zero-stuffer: the comb output SHALL enter the integrators in the cycle after the handshake; zero SHALL be entered on all other cycles.
REQ-018 3 integrators SHALL run every clk with width IN_W+2*R_LOG2+1, two's-complement wrap allowed.
REQ-019 CIC output SHALL be arithmetically right-shifted by 2*R_LOG2 (gain R^2 removed) to give x, IN_W bits.
REQ-020 Modulator, 2nd-order CIFB: fb=+2^(IN_W-1) if dout=1 else -2^(IN_W-1); i1<=i1+x-fb; i2<=i2+i1-fb; integrators IN_W+4 bits, saturating.
REQ-021 dout SHALL be registered: dout<=(i2_next>=0).
REQ-022 Latency: a step on in_data SHALL first affect dout no more than 6 clks after its handshake.
REQ-023 If clear_underrun and a new underrun occur in the same cycle, underrun SHALL be 1 (set wins).

Reset
REQ-024 On reset_n=0, asynchronously: state=IDLE, phase=0, all comb/integrator/modulator registers=0, dout=0, underrun=0, and in_ready SHALL be 1 after release.
REQ-025 Reset mid-RUN SHALL abort immediately; no sample in flight SHALL survive.

Configuration
REQ-026 With CIC3_SDM_DITHER_EN defined, a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) SHALL add ±1 LSB of dither to i2 before the quantizer decision.
REQ-027 Without CIC3_SDM_DITHER_EN, there SHALL be no LFSR and no dither; the quantizer input SHALL be exactly i2_next.

Structure
REQ-028 Package cic3_sdm_pkg SHALL hold the state enum (IDLE, RUN), the default IN_W/R_LOG2 constants, and the derived width functions.
REQ-029 The modulator (REQ-020..021, REQ-026) SHALL be sub-module sdm2_core; the CIC and FSM SHALL be in cic3_sdm_dac.

Verification
REQ-030 Reset, then hold in_valid=0 for 100 clks -> in_ready=1, dout alternates 0101, and underrun=0.
REQ-031 Constant in_data=0 sent every handshake for 8192 clks -> the ones count over the last 4096 clks is 2048±8.
REQ-032 Constant in_data=16'h4000 (+0.5 FS) -> the ones density over 4096 clks after settling is 0.75±0.005; feeding the stream to cic3 decimator gives DC within 0.5%.
REQ-033 Pacing: in_valid held 1 -> in_ready high exactly 1 clk in every 64 in RUN; skip one sample -> underrun=1; clear_underrun -> 0.
REQ-034 Reset asserted mid-RUN at an arbitrary phase -> all outputs reach reset values in the same cycle; the first handshake after release restarts phase at 0.
REQ-035 in_data=16'h7FFF for 10000 clks -> no integrator wrap (saturation hit), and dout stays in bounds with ones density >0.99.
